cls_pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the team's fixed 8-bit carry-select adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit carry-select slices, one pipeline stage per slice, to sustain one operation per clock at wide widths.
- Adds a subtract mode, a signed-overflow flag and valid/ready flow control.
- Sits between operand registers and a result consumer in the arithmetic datapath.

---
 rtl/cls_pipe_adder_if.sv | 26 ++
 rtl/cls_pipe_adder.sv | 107 ++++++++++
 tb/tb_cls_pipe_adder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cls_pipe_adder_if.sv
// Operand and result handshake bundle shared by cls_pipe_adder and whatever drives/consumes it.
interface cls_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_start;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_start, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_start, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/cls_pipe_adder.sv
// Pipelined carry-select add/subtract: one CHUNK-bit slice resolved per stage, one result per clock,
// with a single global enable so the whole pipeline freezes while the consumer stalls.
module cls_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic             clk,
    input logic             rst,
    cls_pipe_adder_if.slave io
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_opA   [STAGES];
    logic [WIDTH-1:0] r_opB   [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_carry [STAGES];
    logic             r_aMsb  [STAGES];
    logic             r_bMsb  [STAGES];

    logic             w_validIn [STAGES];
    logic [WIDTH-1:0] w_opAIn   [STAGES];
    logic [WIDTH-1:0] w_opBIn   [STAGES];
    logic [WIDTH-1:0] w_sumIn   [STAGES];
    logic             w_carryIn [STAGES];
    logic             w_aMsbIn  [STAGES];
    logic             w_bMsbIn  [STAGES];
    logic [CHUNK:0]   w_lo0     [STAGES];
    logic [CHUNK:0]   w_lo1     [STAGES];
    logic [CHUNK:0]   w_sel     [STAGES];
    logic [WIDTH-1:0] w_sumNext [STAGES];

    logic             w_en;
    logic [WIDTH-1:0] w_bEff;
    logic             w_cin;

    assign w_bEff = io.sub ? ~io.b : io.b;
    assign w_cin  = io.sub ? 1'b1 : io.carry_start;

    // Stage 0 takes fresh operands; later stages take the previous stage's registers.
    for (genvar k = 0; k < STAGES; k++) begin : g_link
        if (k == 0) begin : g_head
            assign w_validIn[k] = io.in_valid;
            assign w_opAIn[k]   = io.a;
            assign w_opBIn[k]   = w_bEff;
            assign w_sumIn[k]   = '0;
            assign w_carryIn[k] = w_cin;
            assign w_aMsbIn[k]  = io.a[WIDTH-1];
            assign w_bMsbIn[k]  = w_bEff[WIDTH-1];
        end else begin : g_tail
            assign w_validIn[k] = r_valid[k-1];
            assign w_opAIn[k]   = r_opA[k-1];
            assign w_opBIn[k]   = r_opB[k-1];
            assign w_sumIn[k]   = r_sum[k-1];
            assign w_carryIn[k] = r_carry[k-1];
            assign w_aMsbIn[k]  = r_aMsb[k-1];
            assign w_bMsbIn[k]  = r_bMsb[k-1];
        end

        assign w_lo0[k] = {1'b0, w_opAIn[k][k*CHUNK +: CHUNK]} + {1'b0, w_opBIn[k][k*CHUNK +: CHUNK]};
        assign w_lo1[k] = {1'b0, w_opAIn[k][k*CHUNK +: CHUNK]} + {1'b0, w_opBIn[k][k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, 1'b1};
        assign w_sel[k] = w_carryIn[k] ? w_lo1[k] : w_lo0[k];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sumNext[k] = w_sumIn[k];
            w_sumNext[k][k*CHUNK +: CHUNK] = w_sel[k][CHUNK-1:0];
        end
    end

    assign w_en = !r_valid[LAST] || io.out_ready;

    // Every stage moves together; empty slots advance as bubbles rather than being squeezed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_opA[k]   <= '0;
                r_opB[k]   <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_aMsb[k]  <= 1'b0;
                r_bMsb[k]  <= 1'b0;
            end
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_validIn[k];
                r_opA[k]   <= w_opAIn[k];
                r_opB[k]   <= w_opBIn[k];
                r_sum[k]   <= w_sumNext[k];
                r_carry[k] <= w_sel[k][CHUNK];
                r_aMsb[k]  <= w_aMsbIn[k];
                r_bMsb[k]  <= w_bMsbIn[k];
            end
        end
    end

    assign io.in_ready  = w_en;
    assign io.out_valid = r_valid[LAST];
    assign io.sum       = r_sum[LAST];
    assign io.carry_out = r_carry[LAST];
    // Reset leaves both sign bits and the sum at zero, so this reads 0 out of reset.
    assign io.overflow  = (r_aMsb[LAST] == r_bMsb[LAST]) && (r_sum[LAST][WIDTH-1] != r_aMsb[LAST]);
endmodule

// File: tb/tb_cls_pipe_adder.sv
// Bench for cls_pipe_adder: a 16-bit/4-bit instance for directed, stall, reset and random traffic,
// plus an 8-bit/4-bit instance streamed exhaustively; both scored against a queue-based model.
module tb_cls_pipe_adder;
    logic clk;
    logic rst;

    int checkCount;
    int errorCount;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        int          rem;
    } expT;

    expT q16[$];
    expT q8[$];

    cls_pipe_adder_if #(.WIDTH(16)) if16();
    cls_pipe_adder_if #(.WIDTH(8))  if8();

    cls_pipe_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .io(if16));
    cls_pipe_adder #(.WIDTH(8),  .CHUNK(4)) dut8  (.clk(clk), .rst(rst), .io(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic definition of the result: plain wide addition, then mask to the operand width.
    function automatic expT expectOp(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input logic sub);
        expT         e;
        logic [15:0] mask;
        logic [15:0] bEff;
        logic [16:0] full;
        mask  = 16'((17'h1 << w) - 17'h1);
        bEff  = (sub ? ~b : b) & mask;
        full  = {1'b0, a & mask} + {1'b0, bEff} + 17'(sub ? 1'b1 : cin);
        e.sum = full[15:0] & mask;
        e.co  = full[w];
        e.ov  = (a[w-1] == bEff[w-1]) && (e.sum[w-1] != a[w-1]);
        e.rem = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
        if16.in_valid    = v;
        if16.a           = a;
        if16.b           = b;
        if16.carry_start = cin;
        if16.sub         = sub;
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one op into an empty 16-bit pipeline and pin latency and result to literal values.
    task automatic directedOp(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub, input logic [15:0] expSum,
                              input logic expCo, input logic expOv);
        int cnt;
        applyStimulus(1'b1, a, b, cin, sub);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cnt = 1;
        while (!if16.out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput({name, "_latency"}, 32'(cnt), 32'd4);
        checkOutput({name, "_sum"}, 32'(if16.sum), 32'(expSum));
        checkOutput({name, "_carry"}, 32'(if16.carry_out), 32'(expCo));
        checkOutput({name, "_ovf"}, 32'(if16.overflow), 32'(expOv));
    endtask

    // Model step for the upcoming rising edge, evaluated where inputs and outputs are settled.
    always @(negedge clk) begin
        expT e;
        bit  mv;
        bit  men;
        if (rst) begin
            q16.delete();
            q8.delete();
        end else begin
            mv  = (q16.size() > 0) && (q16[0].rem == 0);
            men = !mv || if16.out_ready;
            checkOutput("in_ready16", 32'(if16.in_ready), 32'(men));
            checkOutput("out_valid16", 32'(if16.out_valid), 32'(mv));
            if (mv) begin
                checkOutput("sum16", 32'(if16.sum), 32'(q16[0].sum));
                checkOutput("carry16", 32'(if16.carry_out), 32'(q16[0].co));
                checkOutput("ovf16", 32'(if16.overflow), 32'(q16[0].ov));
            end
            if (men) begin
                if (mv) void'(q16.pop_front());
                foreach (q16[i]) if (q16[i].rem > 0) q16[i].rem = q16[i].rem - 1;
                if (if16.in_valid) begin
                    e = expectOp(16, if16.a, if16.b, if16.carry_start, if16.sub);
                    e.rem = 3;
                    q16.push_back(e);
                end
            end

            mv  = (q8.size() > 0) && (q8[0].rem == 0);
            men = !mv || if8.out_ready;
            checkOutput("in_ready8", 32'(if8.in_ready), 32'(men));
            checkOutput("out_valid8", 32'(if8.out_valid), 32'(mv));
            if (mv) begin
                checkOutput("sum8", 32'(if8.sum), 32'(q8[0].sum));
                checkOutput("carry8", 32'(if8.carry_out), 32'(q8[0].co));
                checkOutput("ovf8", 32'(if8.overflow), 32'(q8[0].ov));
            end
            if (men) begin
                if (mv) void'(q8.pop_front());
                foreach (q8[i]) if (q8[i].rem > 0) q8[i].rem = q8[i].rem - 1;
                if (if8.in_valid) begin
                    e = expectOp(8, {8'h0, if8.a}, {8'h0, if8.b}, if8.carry_start, if8.sub);
                    e.rem = 1;
                    q8.push_back(e);
                end
            end
        end
    end

    initial begin
        expT e;
        int  sent;
        int  seen;
        bit  accepted;

        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        if16.out_ready   = 1'b1;
        if8.in_valid     = 1'b0;
        if8.a            = 8'h0;
        if8.b            = 8'h0;
        if8.carry_start  = 1'b1;
        if8.sub          = 1'b0;
        if8.out_ready    = 1'b1;

        e = expectOp(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("model_add_ovf", {15'h0, e.co, e.ov, e.sum}, {15'h0, 1'b0, 1'b1, 16'h8000});
        e = expectOp(16, 16'h8000, 16'h0001, 1'b0, 1'b1);
        checkOutput("model_sub_ovf", {15'h0, e.co, e.ov, e.sum}, {15'h0, 1'b1, 1'b1, 16'h7FFF});
        e = expectOp(8, 16'h00FF, 16'h00FF, 1'b1, 1'b0);
        checkOutput("model_8bit", {15'h0, e.co, e.ov, e.sum}, {15'h0, 1'b1, 1'b0, 16'h00FF});

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(if16.out_valid), 32'd0);
        checkOutput("rst_sum", 32'(if16.sum), 32'd0);
        checkOutput("rst_carry", 32'(if16.carry_out), 32'd0);
        checkOutput("rst_ovf", 32'(if16.overflow), 32'd0);
        checkOutput("rst_in_ready", 32'(if16.in_ready), 32'd1);
        @(posedge clk);
        #1;

        directedOp("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        directedOp("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directedOp("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directedOp("sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directedOp("sub_0005", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        idle(6);

        // Back-to-back stream with the consumer stalled for cycles 5..8.
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            if16.out_ready = !(c >= 5 && c <= 8);
            applyStimulus(sent < 8, 16'(sent), 16'(sent) << 4, 1'b0, 1'b0);
            @(negedge clk);
            accepted = if16.in_valid && if16.in_ready;
            @(posedge clk);
            #1;
            if (accepted) sent++;
        end
        if16.out_ready = 1'b1;
        checkOutput("stream_accepted", 32'(sent), 32'd8);
        idle(4);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'(i + 1) * 16'h0111, 16'h0101, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if16.out_valid) seen++;
        end
        checkOutput("rst_flush", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        directedOp("post_rst", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        idle(4);

        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    applyStimulus(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                                  1'($urandom), 1'($urandom));
                    if16.out_ready = ($urandom % 4) != 0;
                    @(posedge clk);
                    #1;
                end
                applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
                if16.out_ready = 1'b1;
            end
            begin
                for (int x = 0; x < 65536; x++) begin
                    if8.in_valid    = 1'b1;
                    if8.a           = 8'(x >> 8);
                    if8.b           = 8'(x);
                    if8.carry_start = 1'b1;
                    if8.sub         = 1'b0;
                    @(posedge clk);
                    #1;
                end
                if8.in_valid = 1'b0;
            end
        join

        idle(10);
        checkOutput("drain16", 32'(q16.size()), 32'd0);
        checkOutput("drain8", 32'(q8.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
